usb_data_framer: RTL and testbench

Packet framer directly downstream of `crc16_gen` in the USB transmit path. It captures a 64-bit payload when the payload is presented, then captures the matching CRC16 one cycle later. It emits a complete USB DATA0/DATA1 packet body as a byte stream over a valid/ready handshake: PID, 8 data bytes, 2 CRC bytes. The byte-serial consumer is the NRZI/bit-stuff encoder. The block also tracks the DATA0/DATA1 sequence bit across packets.

---
 rtl/usb_data_framer.sv | 175 +++++++++++++++++
 tb/tb_usb_data_framer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_data_framer.sv
// USB DATA0/DATA1 packet framer: latches a payload and its CRC16, then streams
// PID, payload bytes (LSB first) and the complemented CRC over valid/ready.
module usb_data_framer #(
  parameter int PAYLOAD_BYTES = 8
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [8*PAYLOAD_BYTES-1:0] rcv_data,
  input  logic                       data_ready,
  input  logic [15:0]                trans_crc,
  input  logic                       tx_ready,
  input  logic                       toggle_seq,
  input  logic                       clear_seq,
  output logic [7:0]                 tx_byte,
  output logic                       tx_valid,
  output logic                       tx_last,
  output logic                       busy,
  output logic                       pkt_done,
  output logic                       overrun
);

  localparam int CNT_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAYLOAD_BYTES - 1);
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRC_WAIT,
    S_PID,
    S_DATA,
    S_CRC_LO,
    S_CRC_HI
  } state_t;

  state_t                     state_q, state_d;
  logic [8*PAYLOAD_BYTES-1:0] payload_q, payload_d;
  logic [15:0]                crc_q, crc_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       seq_q, seq_d;
  logic                       pid_seq_q, pid_seq_d;
  logic [7:0]                 tx_byte_q, tx_byte_d;
  logic                       tx_valid_q, tx_valid_d;
  logic                       tx_last_q, tx_last_d;
  logic                       busy_q, busy_d;
  logic                       pkt_done_q, pkt_done_d;
  logic                       overrun_q, overrun_d;
  logic                       xfer;
  logic [CNT_W-1:0]           cnt_nx;
  logic [CNT_W+2:0]           byte_idx;

  // Handshake: a byte moves on a rising edge with tx_valid && tx_ready; while
  // tx_valid is high and tx_ready low, tx_byte/tx_last/state hold unchanged.
  always_comb begin
    state_d    = state_q;
    payload_d  = payload_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    pid_seq_d  = pid_seq_q;
    tx_byte_d  = tx_byte_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    pkt_done_d = 1'b0;
    overrun_d  = data_ready && (state_q != S_IDLE);
    xfer       = tx_valid_q && tx_ready;
    cnt_nx     = cnt_q + 1'b1;
    byte_idx   = {cnt_nx, 3'b000};

    if (clear_seq) begin
      seq_d = 1'b0;
    end else if (toggle_seq) begin
      seq_d = ~seq_q;
    end else begin
      seq_d = seq_q;
    end

    case (state_q)
      S_IDLE: begin
        if (data_ready) begin
          state_d   = S_CRC_WAIT;
          payload_d = rcv_data;
          pid_seq_d = seq_q;
        end
      end
      S_CRC_WAIT: begin
        // crc16_gen hands over the raw remainder; the wire carries its complement.
        crc_d      = ~trans_crc;
        state_d    = S_PID;
        tx_valid_d = 1'b1;
        tx_byte_d  = pid_seq_q ? PID_DATA1 : PID_DATA0;
      end
      S_PID: begin
        if (xfer) begin
          state_d   = S_DATA;
          cnt_d     = '0;
          tx_byte_d = payload_q[7:0];
        end
      end
      S_DATA: begin
        if (xfer) begin
          if (cnt_q == LAST_IDX) begin
            state_d   = S_CRC_LO;
            tx_byte_d = crc_q[7:0];
          end else begin
            cnt_d     = cnt_nx;
            tx_byte_d = payload_q[byte_idx +: 8];
          end
        end
      end
      S_CRC_LO: begin
        if (xfer) begin
          state_d   = S_CRC_HI;
          tx_byte_d = crc_q[15:8];
          tx_last_d = 1'b1;
        end
      end
      S_CRC_HI: begin
        if (xfer) begin
          state_d    = S_IDLE;
          tx_byte_d  = 8'h00;
          tx_valid_d = 1'b0;
          tx_last_d  = 1'b0;
          cnt_d      = '0;
          pkt_done_d = 1'b1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        tx_byte_d  = 8'h00;
        tx_valid_d = 1'b0;
        tx_last_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      payload_q  <= '0;
      crc_q      <= '0;
      cnt_q      <= '0;
      seq_q      <= 1'b0;
      pid_seq_q  <= 1'b0;
      tx_byte_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      pkt_done_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      payload_q  <= payload_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      seq_q      <= seq_d;
      pid_seq_q  <= pid_seq_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      busy_q     <= busy_d;
      pkt_done_q <= pkt_done_d;
      overrun_q  <= overrun_d;
    end
  end

  assign tx_byte  = tx_byte_q;
  assign tx_valid = tx_valid_q;
  assign tx_last  = tx_last_q;
  assign busy     = busy_q;
  assign pkt_done = pkt_done_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_usb_data_framer.sv
// Bench for usb_data_framer: a queue-based packet model checked every cycle,
// directed scenarios with literal byte expectations, then randomized traffic.
module tb_usb_data_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] rcv_data = '0;
  logic        data_ready = 1'b0;
  logic [15:0] trans_crc = '0;
  logic        tx_ready = 1'b1;
  logic        toggle_seq = 1'b0;
  logic        clear_seq = 1'b0;
  logic [7:0]  tx_byte;
  logic        tx_valid, tx_last, busy, pkt_done, overrun;

  int n_cmp = 0;
  int n_fail = 0;
  int rdy_mode = 0;

  usb_data_framer #(.PAYLOAD_BYTES(8)) dut (
    .clk(clk), .n_rst(rst_n), .rcv_data(rcv_data), .data_ready(data_ready),
    .trans_crc(trans_crc), .tx_ready(tx_ready), .toggle_seq(toggle_seq),
    .clear_seq(clear_seq), .tx_byte(tx_byte), .tx_valid(tx_valid),
    .tx_last(tx_last), .busy(busy), .pkt_done(pkt_done), .overrun(overrun)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic        m_wait = 1'b0;
  logic        m_seq = 1'b0;
  logic [7:0]  m_pid = 8'h00;
  logic [63:0] m_pay = '0;
  logic        e_done = 1'b0;
  logic        e_ovr = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    logic busy_now, xfer;
    logic [15:0] c;
    if (!rst_n) begin
      exp_q.delete();
      m_wait = 1'b0;
      m_seq  = 1'b0;
      m_pid  = 8'h00;
      m_pay  = '0;
      e_done = 1'b0;
      e_ovr  = 1'b0;
    end else begin
      busy_now = m_wait || (exp_q.size() != 0);
      xfer     = (exp_q.size() != 0) && tx_ready;
      e_ovr    = data_ready && busy_now;
      e_done   = xfer && (exp_q.size() == 1);
      if (m_wait) begin
        m_wait = 1'b0;
        c = ~trans_crc;
        exp_q.push_back(m_pid);
        for (int k = 0; k < 8; k++) exp_q.push_back(m_pay[8*k +: 8]);
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
      end else if (xfer) begin
        void'(exp_q.pop_front());
      end
      if (!busy_now && data_ready) begin
        m_wait = 1'b1;
        m_pay  = rcv_data;
        m_pid  = m_seq ? 8'h4B : 8'hC3;
      end
      if (clear_seq) m_seq = 1'b0;
      else if (toggle_seq) m_seq = ~m_seq;
    end
  end

  always @(posedge clk) begin
    if (rst_n && tx_valid && tx_ready) got_q.push_back(tx_byte);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("tx_valid", tx_valid, exp_q.size() != 0);
      chk("tx_byte", tx_byte, (exp_q.size() != 0) ? exp_q[0] : 8'h00);
      chk("tx_last", tx_last, exp_q.size() == 1);
      chk("busy", busy, m_wait || (exp_q.size() != 0));
      chk("pkt_done", pkt_done, e_done);
      chk("overrun", overrun, e_ovr);
    end
  end

  // ---------------- drivers ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_ready = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send(input logic [63:0] d, input logic [15:0] c);
    @(posedge clk);
    #1;
    rcv_data   = d;
    data_ready = 1'b1;
    trans_crc  = 16'($urandom);
    @(posedge clk);
    #1;
    data_ready = 1'b0;
    trans_crc  = c;
  endtask

  task automatic pulse(input logic tog, input logic clr);
    @(posedge clk);
    #1;
    toggle_seq = tog;
    clear_seq  = clr;
    @(posedge clk);
    #1;
    toggle_seq = 1'b0;
    clear_seq  = 1'b0;
  endtask

  task automatic wait_idle(input logic inject);
    int n = 0;
    while ((m_wait || exp_q.size() != 0) && n < 2000) begin
      @(posedge clk);
      #1;
      if (inject) begin
        data_ready = ($urandom_range(0, 7) == 0);
        rcv_data   = {$urandom, $urandom};
        trans_crc  = 16'($urandom);
        toggle_seq = ($urandom_range(0, 9) == 0);
      end
      n++;
    end
    data_ready = 1'b0;
    toggle_seq = 1'b0;
    @(negedge clk);
    chk("idle_timeout", n < 2000, 1'b1);
  endtask

  task automatic chk_pkt(input string nm, input logic [7:0] lit [11]);
    chk({nm, "_count"}, got_q.size(), 11);
    for (int i = 0; i < 11; i++) chk(nm, (i < got_q.size()) ? got_q[i] : 8'hxx, lit[i]);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    logic [7:0] lit_zero [11];
    logic [7:0] lit_seq [11];
    int n;
    lit_zero = '{8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
    lit_seq  = '{8'hC3, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hCB, 8'hED};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // zero payload, latency pins
    got_q.delete();
    send(64'h0, 16'h0000);
    @(negedge clk);
    chk("lat_busy", busy, 1'b1);
    chk("lat_valid_early", tx_valid, 1'b0);
    @(negedge clk);
    chk("lat_valid", tx_valid, 1'b1);
    chk("lat_pid", tx_byte, 8'hC3);
    wait_idle(1'b0);
    chk_pkt("pkt_zero", lit_zero);

    got_q.delete();
    send(64'h0807060504030201, 16'h1234);
    wait_idle(1'b0);
    chk_pkt("pkt_seq", lit_seq);

    rdy_mode = 1;
    got_q.delete();
    send(64'h0807060504030201, 16'h1234);
    wait_idle(1'b0);
    chk_pkt("pkt_stall", lit_seq);

    // sequence bit
    pulse(1'b1, 1'b0);
    got_q.delete();
    send(64'h0807060504030201, 16'h1234);
    wait_idle(1'b0);
    chk("pid_toggle1", got_q[0], 8'h4B);
    pulse(1'b1, 1'b0);
    got_q.delete();
    send(64'h1122334455667788, 16'hBEEF);
    wait_idle(1'b0);
    chk("pid_toggle2", got_q[0], 8'hC3);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b1);
    got_q.delete();
    send(64'h1122334455667788, 16'hBEEF);
    wait_idle(1'b0);
    chk("pid_clear_wins", got_q[0], 8'hC3);

    got_q.delete();
    send(64'hA5A5A5A5A5A5A5A5, 16'h0F0F);
    repeat (3) @(posedge clk);
    pulse(1'b1, 1'b0);
    wait_idle(1'b0);
    chk("pid_mid_toggle", got_q[0], 8'hC3);
    got_q.delete();
    send(64'hA5A5A5A5A5A5A5A5, 16'h0F0F);
    wait_idle(1'b0);
    chk("pid_after_mid", got_q[0], 8'h4B);
    pulse(1'b0, 1'b1);

    // overrun during DATA
    rdy_mode = 0;
    got_q.delete();
    send(64'h0807060504030201, 16'h1234);
    repeat (3) @(posedge clk);
    #1;
    rcv_data   = 64'hFFFF_FFFF_FFFF_FFFF;
    data_ready = 1'b1;
    @(posedge clk);
    #1;
    data_ready = 1'b0;
    @(negedge clk);
    chk("overrun_pulse", overrun, 1'b1);
    wait_idle(1'b0);
    chk_pkt("pkt_overrun", lit_seq);

    // back-to-back acceptance in the pkt_done cycle
    got_q.delete();
    send(64'h0, 16'h0000);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pkt_done && n < 100);
    chk("b2b_done_seen", pkt_done, 1'b1);
    chk_pkt("pkt_b2b_a", lit_zero);
    got_q.delete();
    rcv_data   = 64'h0807060504030201;
    data_ready = 1'b1;
    @(posedge clk);
    #1;
    data_ready = 1'b0;
    trans_crc  = 16'h1234;
    @(negedge clk);
    chk("b2b_busy", busy, 1'b1);
    @(negedge clk);
    chk("b2b_pid", tx_byte, 8'hC3);
    wait_idle(1'b0);
    chk_pkt("pkt_b2b_b", lit_seq);

    // reset during DATA byte 3
    pulse(1'b1, 1'b0);
    got_q.delete();
    send(64'h0807060504030201, 16'h1234);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (got_q.size() < 4 && n < 100);
    chk("pre_rst_byte3", tx_byte, 8'h04);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", tx_valid, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_byte", tx_byte, 8'h00);
    chk("rst_mid_done", pkt_done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    send(64'h0807060504030201, 16'h1234);
    wait_idle(1'b0);
    chk_pkt("pkt_after_rst", lit_seq);

    // randomized traffic
    rdy_mode = 1;
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 2) == 0) pulse(1'b1, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) pulse(1'b0, 1'b1);
      send({$urandom, $urandom}, 16'($urandom));
      wait_idle(1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
